// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial sequencer for an external 1-bit fullAdder. On an accepted start
// it captures two WIDTH-bit operands and a carry-in. It then feeds the adder
// one bit pair per clock, LSB first, and keeps the carry in a register
// between bits. The sum bits are shifted in from the top, so after WIDTH
// cycles the assembled word is in bit order.
//
// Optional feature (compile-time macro SERIAL_ADDER_OVF_EN):
//   defined     -> ovf reports signed overflow of the last add
//                  (carry into MSB xor carry out of MSB)
//   not defined -> ovf is tied low and costs no flops
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      synchronous active-low reset
//   start     in   1      add request, sampled only in IDLE or DONE
//   a_in      in   WIDTH  operand A, captured on the accepted start
//   b_in      in   WIDTH  operand B, captured on the accepted start
//   cin_in    in   1      initial carry, captured on the accepted start
//   fa_a      out  1      to fullAdder.A   (0 outside RUN)
//   fa_b      out  1      to fullAdder.B   (0 outside RUN)
//   fa_cin    out  1      to fullAdder.cin (0 outside RUN)
//   fa_sum    in   1      from fullAdder.sum
//   fa_cout   in   1      from fullAdder.cout
//   busy      out  1      high while the add is in progress
//   done      out  1      one-cycle pulse when result/cout_out become valid
//   result    out  WIDTH  sum, held until the next accepted start completes
//   cout_out  out  1      final carry, held like result
//   ovf       out  1      signed overflow (see macro above)
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_out,
    output logic             ovf
);

    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  aShift_q, aShift_d;
    logic [WIDTH-1:0]  bShift_q, bShift_d;
    logic [WIDTH-1:0]  sumShift_q, sumShift_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [WIDTH-1:0]  sumNext;

    // The sum word after this cycle's bit has been shifted in at the top.
    // A one-bit word has no lower part to keep, hence the split.
    generate
        if (WIDTH == 1) begin : gNarrowSum
            assign sumNext = fa_sum;
        end else begin : gWideSum
            assign sumNext = {fa_sum, sumShift_q[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif

    // State and datapath registers. Reset is synchronous, so an add in
    // progress is dropped cleanly at the next edge and never raises done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            aShift_q   <= '0;
            bShift_q   <= '0;
            sumShift_q <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            aShift_q   <= aShift_d;
            bShift_q   <= bShift_d;
            sumShift_q <= sumShift_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            cout_q     <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    // Next-state and adder-drive logic. Every register holds by default.
    // A start is honoured only when not running, so an add in flight is
    // never restarted and requests are not queued.
    always_comb begin
        state_d    = state_q;
        aShift_d   = aShift_q;
        bShift_d   = bShift_q;
        sumShift_d = sumShift_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d      = ovf_q;
`endif
        fa_a       = 1'b0;
        fa_b       = 1'b0;
        fa_cin     = 1'b0;

        case (state_q)
            RUN: begin
                fa_a       = aShift_q[0];
                fa_b       = bShift_q[0];
                fa_cin     = carry_q;
                aShift_d   = aShift_q >> 1;
                bShift_d   = bShift_q >> 1;
                sumShift_d = sumNext;
                carry_d    = fa_cout;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB position
                    result_d = sumNext;
                    cout_d   = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d    = carry_q ^ fa_cout;
`endif
                    state_d  = DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE otherwise
                // falls back to IDLE so done lasts exactly one cycle.
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    aShift_d   = a_in;
                    bShift_d   = b_in;
                    carry_d    = cin_in;
                    cnt_d      = '0;
                    sumShift_d = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d      = 1'b0;
`endif
                    state_d    = RUN;
                end
            end
        endcase
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign cout_out = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
